// File: rtl/fc_pkg.sv
// fc_pkg: shared widths, FSM states and the round/saturate helper
// for the fully-connected layer engine.
package fc_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;
  localparam int ACC_WIDTH  = 40;
  localparam int LANES      = 8;
  localparam int MAX_IN     = 512;
  localparam int MAX_OUT    = 128;

  localparam int AW  = $clog2(MAX_IN + 1);
  localparam int OW  = $clog2(MAX_OUT + 1);
  localparam int GW  = $clog2(MAX_OUT / LANES + 1);
  localparam int WAW = $clog2((MAX_OUT / LANES) * (MAX_IN + 1));
  localparam int LB  = $clog2(LANES);
  localparam int PW  = 2 * DATA_WIDTH;

  localparam logic [DATA_WIDTH-1:0] ONE =
    DATA_WIDTH'(1 << FRAC_BITS);

  localparam logic signed [ACC_WIDTH-1:0] HALF =
    ACC_WIDTH'(1 << (FRAC_BITS - 1));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } fc_state_e;

  // Round half up at the binary point, then clamp to DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] round_sat(
    input logic signed [ACC_WIDTH-1:0] a
  );
    logic signed [ACC_WIDTH-1:0] s;
    logic [DATA_WIDTH-1:0] r;
    s = (a + HALF) >>> FRAC_BITS;
    if (s > SAT_MAX)
      r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (s < SAT_MIN)
      r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      r = s[DATA_WIDTH-1:0];
    return r;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// fc_mac_lane: one output neuron's accumulator with
// round/saturate and optional ReLU on the result.
module fc_mac_lane
  import fc_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic                  relu_i,
  input  logic [DATA_WIDTH-1:0] act_i,
  input  logic [DATA_WIDTH-1:0] w_i,
  output logic [DATA_WIDTH-1:0] res_o
);

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [PW-1:0]        prod;
  logic [DATA_WIDTH-1:0]       rs;

  assign prod = PW'($signed(act_i)) * PW'($signed(w_i));

  always_comb begin
    acc_d = acc_q;
    if (clr_i)
      acc_d = '0;
    else if (en_i)
      acc_d = acc_q +
        {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      acc_q <= '0;
    else
      acc_q <= acc_d;
  end

  assign rs = round_sat(acc_q);
  assign res_o = (relu_i && rs[DATA_WIDTH-1]) ? '0 : rs;

endmodule

// File: rtl/fc_layer_engine.sv
// fc_layer_engine: time-multiplexed FC layer, LANES neurons per pass.
// Define FC_ARGMAX_EN to add a running argmax over written outputs.
module fc_layer_engine
  import fc_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [AW-1:0]               cfg_in_nodes,
  input  logic [OW-1:0]               cfg_out_nodes,
  input  logic                        cfg_bias,
  input  logic                        cfg_relu,
  output logic                        busy,
  output logic                        done,
  output logic                        act_rd_en,
  output logic [AW-1:0]               act_rd_addr,
  input  logic [DATA_WIDTH-1:0]       act_rd_data,
  output logic                        w_rd_en,
  output logic [WAW-1:0]              w_rd_addr,
  input  logic [LANES*DATA_WIDTH-1:0] w_rd_data,
  output logic                        out_wr_en,
  output logic [GW-1:0]               out_wr_addr,
  output logic [LANES*DATA_WIDTH-1:0] out_wr_data,
  output logic [LANES-1:0]            out_wr_mask
`ifdef FC_ARGMAX_EN
  ,
  output logic [OW-1:0]               max_idx,
  output logic [DATA_WIDTH-1:0]       max_val
`endif
);

  fc_state_e state_q, state_d;

  logic [AW-1:0]  in_q, k_q, i_q, k_in;
  logic [OW-1:0]  out_q;
  logic [GW-1:0]  ngrp_q, g_q, g_in;
  logic [WAW-1:0] wbase_q;
  logic [OW:0]    out_rnd;
  logic           relu_q, mac_v_q, bias_st_q;
  logic           accept, last_grp;
  fc_state_e      first_st;

  logic [DATA_WIDTH-1:0] act_op;
  logic [DATA_WIDTH-1:0] res [LANES];
  logic [LANES-1:0]      grp_mask;

  assign k_in    = cfg_in_nodes + AW'(cfg_bias);
  assign out_rnd = {1'b0, cfg_out_nodes} + (OW+1)'(LANES - 1);
  assign g_in    = GW'(out_rnd >> LB);

  assign accept = start &&
    (state_q == S_IDLE || state_q == S_DONE);
  // Empty layers and K==0 skip straight to DRAIN.
  assign first_st = (g_in == '0 || k_in == '0) ? S_DRAIN : S_MAC;
  assign last_grp = (g_q == ngrp_q - GW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept) state_d = first_st;
      S_MAC:
        if (i_q == k_q - AW'(1)) state_d = S_DRAIN;
      S_DRAIN:
        state_d = (ngrp_q == '0) ? S_DONE : S_WRITE;
      S_WRITE:
        if (last_grp)        state_d = S_DONE;
        else if (k_q == '0)  state_d = S_DRAIN;
        else                 state_d = S_MAC;
      S_DONE:
        state_d = accept ? first_st : S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_MAC) || (state_q == S_DRAIN) ||
                (state_q == S_WRITE);
  assign done = (state_q == S_DONE);

  assign w_rd_en   = (state_q == S_MAC);
  assign act_rd_en = w_rd_en && (i_q < in_q);
  assign out_wr_en = (state_q == S_WRITE);

  assign act_rd_addr = act_rd_en ? i_q : '0;
  assign w_rd_addr   = w_rd_en ? wbase_q + WAW'(i_q) : '0;
  assign out_wr_addr = out_wr_en ? g_q : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q      <= '0;
      k_q       <= '0;
      out_q     <= '0;
      ngrp_q    <= '0;
      relu_q    <= 1'b0;
      i_q       <= '0;
      g_q       <= '0;
      wbase_q   <= '0;
      mac_v_q   <= 1'b0;
      bias_st_q <= 1'b0;
    end else begin
      mac_v_q   <= w_rd_en;
      bias_st_q <= w_rd_en && !act_rd_en;
      if (accept) begin
        in_q    <= cfg_in_nodes;
        k_q     <= k_in;
        out_q   <= cfg_out_nodes;
        ngrp_q  <= g_in;
        relu_q  <= cfg_relu;
        i_q     <= '0;
        g_q     <= '0;
        wbase_q <= '0;
      end else if (state_q == S_MAC) begin
        i_q <= i_q + AW'(1);
      end else if (state_q == S_WRITE) begin
        i_q     <= '0;
        g_q     <= g_q + GW'(1);
        wbase_q <= wbase_q + WAW'(k_q);
      end
    end
  end

  // Bias step substitutes a constant 1.0 for the activation.
  assign act_op = bias_st_q ? ONE : act_rd_data;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fc_mac_lane u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (mac_v_q),
      .clr_i   (out_wr_en),
      .relu_i  (relu_q),
      .act_i   (act_op),
      .w_i     (w_rd_data[l*DATA_WIDTH +: DATA_WIDTH]),
      .res_o   (res[l])
    );
  end

  always_comb begin
    grp_mask    = '0;
    out_wr_data = '0;
    for (int l = 0; l < LANES; l++) begin
      grp_mask[l] = OW'({g_q, LB'(l)}) < out_q;
      if (out_wr_en)
        out_wr_data[l*DATA_WIDTH +: DATA_WIDTH] = res[l];
    end
  end

  assign out_wr_mask = out_wr_en ? grp_mask : '0;

`ifdef FC_ARGMAX_EN
  logic                  mx_vld_q, mx_vld_d;
  logic [OW-1:0]         mx_idx_q, mx_idx_d;
  logic [DATA_WIDTH-1:0] mx_val_q, mx_val_d;

  // Strict compare in index order keeps the lowest index on ties.
  always_comb begin
    mx_vld_d = mx_vld_q;
    mx_idx_d = mx_idx_q;
    mx_val_d = mx_val_q;
    for (int l = 0; l < LANES; l++) begin
      if (grp_mask[l] && (!mx_vld_d ||
          $signed(res[l]) > $signed(mx_val_d))) begin
        mx_vld_d = 1'b1;
        mx_idx_d = OW'({g_q, LB'(l)});
        mx_val_d = res[l];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mx_vld_q <= 1'b0;
      mx_idx_q <= '0;
      mx_val_q <= '0;
    end else if (accept) begin
      mx_vld_q <= 1'b0;
      mx_idx_q <= '0;
      mx_val_q <= '0;
    end else if (out_wr_en) begin
      mx_vld_q <= mx_vld_d;
      mx_idx_q <= mx_idx_d;
      mx_val_q <= mx_val_d;
    end
  end

  assign max_idx = mx_idx_q;
  assign max_val = mx_val_q;
`endif

endmodule
